// File: rtl/xge_tx_pkt_arbiter.sv
// xge_tx_pkt_arbiter
// Round-robin arbiter sharing the xge_mac packet TX interface between NUM_REQ
// packet sources. Grants change only on packet boundaries: a granted source
// keeps the MAC until its eop beat is accepted, then loses priority.
// One IDLE cycle is spent arbitrating between packets. Accepted beats reach
// the MAC one cycle later through the output register.
//
// Optional feature: define XGE_TX_ARB_STATS_EN to add pkt_cnt, a set of
// per-source 32-bit wrapping counters of packets whose eop beat was accepted.
module xge_tx_pkt_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                      clk_156m25,
    input  logic                      reset_156m25_n,
    input  logic [NUM_REQ-1:0]        req_val,
    input  logic [NUM_REQ-1:0]        req_sop,
    input  logic [NUM_REQ-1:0]        req_eop,
    input  logic [NUM_REQ*3-1:0]      req_mod,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      pkt_tx_full,
    output logic                      pkt_tx_val,
    output logic                      pkt_tx_sop,
    output logic                      pkt_tx_eop,
    output logic [2:0]                pkt_tx_mod,
    output logic [DATA_W-1:0]         pkt_tx_data,
    output logic [1:0]                grant_id,
    output logic                      busy
`ifdef XGE_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     pkt_cnt
`endif
);

    localparam int unsigned MOD_W = 3;
    localparam int unsigned GID_W = 2;
`ifdef XGE_TX_ARB_STATS_EN
    localparam int unsigned CNT_W = 32;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic               out_val_q, out_val_d;
    beat_t              out_beat_q, out_beat_d;

    logic [NUM_REQ-1:0] req_c;
    logic               win_found_c;
    logic [GID_W-1:0]   win_idx_c;
    beat_t              sel_beat_c;
    logic               sel_val_c;
    logic               accept_c;

    // A source requests when it presents a start-of-packet beat
    assign req_c = req_val & req_sop;

    // Rotating priority: lowest index at or above rr_ptr wins, else lowest below it
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_c[i] && (GID_W'(i) < rr_ptr_q)) begin
                win_found_c = 1'b1;
                win_idx_c   = GID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_c[i] && (GID_W'(i) >= rr_ptr_q)) begin
                win_found_c = 1'b1;
                win_idx_c   = GID_W'(i);
            end
        end
    end

    // Select the granted source's beat
    always_comb begin
        sel_beat_c = '0;
        sel_val_c  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GID_W'(i)) begin
                sel_val_c       = req_val[i];
                sel_beat_c.sop  = req_sop[i];
                sel_beat_c.eop  = req_eop[i];
                sel_beat_c.mod  = req_mod[MOD_W*i +: MOD_W];
                sel_beat_c.data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state, handshake and output-register load decisions
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        out_val_d  = 1'b0;
        out_beat_d = out_beat_q;
        req_ready  = '0;
        accept_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    grant_d = win_idx_c;
                    state_d = XFER;
                end
            end
            XFER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == GID_W'(i)) begin
                        req_ready[i] = ~pkt_tx_full;
                    end
                end
                accept_c = sel_val_c & ~pkt_tx_full;
                if (accept_c) begin
                    out_val_d  = 1'b1;
                    out_beat_d = sel_beat_c;
                    if (sel_beat_c.eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == GID_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_q + GID_W'(1);
                    end
                end
            end
        endcase
    end

    // State, pointer and MAC output registers; reset aborts any packet in flight
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            out_val_q  <= 1'b0;
            out_beat_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            out_val_q  <= out_val_d;
            out_beat_q <= out_beat_d;
        end
    end

    assign pkt_tx_val  = out_val_q;
    assign pkt_tx_sop  = out_beat_q.sop;
    assign pkt_tx_eop  = out_beat_q.eop;
    assign pkt_tx_mod  = out_beat_q.mod;
    assign pkt_tx_data = out_beat_q.data;
    assign grant_id    = grant_q;
    assign busy        = (state_q == XFER);

`ifdef XGE_TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Count packets per source when their eop beat is accepted
    always_comb begin
        cnt_d = cnt_q;
        if (accept_c && sel_beat_c.eop) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q == GID_W'(i)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Packet counter registers
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_xge_tx_pkt_arbiter.sv
// Directed bench for xge_tx_pkt_arbiter: per-source beat queues feed the
// DUT, an expected-beat scoreboard is checked at the MAC side.
// Counter tests are included when XGE_TX_ARB_STATS_EN is defined.
module tb_xge_tx_pkt_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 64;

    typedef struct packed {
        logic [1:0]    src;
        logic          sop;
        logic          eop;
        logic [2:0]    mod;
        logic [DW-1:0] data;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_val = '0;
    logic [NREQ-1:0]      req_sop = '0;
    logic [NREQ-1:0]      req_eop = '0;
    logic [NREQ*3-1:0]    req_mod = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 full = 1'b0;
    logic                 pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]           pkt_tx_mod;
    logic [DW-1:0]        pkt_tx_data;
    logic [1:0]           grant_id;
    logic                 busy;
`ifdef XGE_TX_ARB_STATS_EN
    logic [NREQ*32-1:0]   pkt_cnt;
`endif

    xge_tx_pkt_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .req_val        (req_val),
        .req_sop        (req_sop),
        .req_eop        (req_eop),
        .req_mod        (req_mod),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .pkt_tx_full    (full),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_data    (pkt_tx_data),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef XGE_TX_ARB_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t       srcq [NREQ][$];
    beat_t       expq [$];
    int unsigned val_cyc [$];
    int unsigned exp_off [$];
    int          errors = 0;
    int          checks = 0;
    logic        busy_at_eop = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a packet at a source and its expected MAC beats on the scoreboard
    task automatic push_pkt(input int src, input int nb, input logic [7:0] base, input logic [2:0] last_mod);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.src  = 2'(src);
            b.sop  = (k == 0);
            b.eop  = (k == nb - 1);
            b.mod  = (k == nb - 1) ? last_mod : 3'd0;
            b.data = {8{8'(base + 8'h11 * k)}};
            srcq[src].push_back(b);
            expq.push_back(b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int s = 0; s < NREQ; s++) srcq[s].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((srcq[0].size() != 0 || srcq[1].size() != 0 || expq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        assert (n < 300) else begin
            errors++;
            $error("FAIL %s_timeout: waited %0d cycles, limit 300", tag, n);
        end
    endtask

    // MAC beat spacing relative to the first beat of the test
    task automatic chk_spacing(input string tag);
        chk({tag, "_count"}, 128'(val_cyc.size()), 128'(exp_off.size()));
        for (int k = 0; k < exp_off.size() && k < val_cyc.size(); k++)
            chk({tag, "_offset"}, 128'(val_cyc[k] - val_cyc[0]), 128'(exp_off[k]));
    endtask

    // Source models: present queue heads, retire a beat once accepted
    initial begin
        logic [NREQ-1:0] take;
        beat_t hd;
        forever begin
            @(negedge clk);
            take = req_val & req_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NREQ; s++) begin
                if (take[s] && srcq[s].size() != 0) void'(srcq[s].pop_front());
                if (srcq[s].size() != 0) begin
                    hd = srcq[s][0];
                    req_val[s] = 1'b1;
                    req_sop[s] = hd.sop;
                    req_eop[s] = hd.eop;
                    req_mod[3*s +: 3]    = hd.mod;
                    req_data[DW*s +: DW] = hd.data;
                end else begin
                    req_val[s] = 1'b0;
                    req_sop[s] = 1'b0;
                    req_eop[s] = 1'b0;
                end
            end
        end
    end

    // MAC-side monitor and scoreboard
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        if (rst_n && pkt_tx_val) begin
            val_cyc.push_back(cyc);
            got = {grant_id, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
            if (pkt_tx_eop) busy_at_eop = busy;
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra_beat: got %0h expected no beat", got);
            end
            if (expq.size() != 0) begin
                exp = expq.pop_front();
                chk("sb_beat", 128'(got), 128'(exp));
            end
        end
    end

    initial begin
        int          n;
        int unsigned c0;
        int          pulses;

        repeat (3) @(negedge clk);
        chk("rst_val",   128'(pkt_tx_val),  128'(0));
        chk("rst_sop",   128'(pkt_tx_sop),  128'(0));
        chk("rst_eop",   128'(pkt_tx_eop),  128'(0));
        chk("rst_mod",   128'(pkt_tx_mod),  128'(0));
        chk("rst_data",  128'(pkt_tx_data), 128'(0));
        chk("rst_grant", 128'(grant_id),    128'(0));
        chk("rst_busy",  128'(busy),        128'(0));
        chk("rst_ready", 128'(req_ready),   128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Source 0 alone: 3-beat packet
        val_cyc.delete();
        busy_at_eop = 1'b1;
        push_pkt(0, 3, 8'h11, 3'd4);
        n = 0;
        while (!req_val[0] && n < 10) begin @(negedge clk); n++; end
        c0 = cyc;
        drain("single_src");
        chk("first_latency", 128'(val_cyc.size() != 0 ? val_cyc[0] - c0 : 0), 128'(2));
        exp_off = {0, 1, 2};
        chk_spacing("single_src");
        chk("busy_at_eop", 128'(busy_at_eop), 128'(0));
        chk("rr_ptr_after", 128'(dut.rr_ptr_q), 128'(1));

        // Simultaneous requests after reset: order 0,1,0,1 with 1 idle cycle
        do_reset();
        val_cyc.delete();
        push_pkt(0, 2, 8'h40, 3'd1);
        push_pkt(1, 2, 8'h50, 3'd2);
        push_pkt(0, 2, 8'h60, 3'd3);
        push_pkt(1, 2, 8'h70, 3'd5);
        drain("rr");
        exp_off = {0, 1, 3, 4, 6, 7, 9, 10};
        chk_spacing("rr");

        // Backpressure: full for 4 cycles inside a 6-beat packet
        val_cyc.delete();
        push_pkt(0, 6, 8'h80, 3'd6);
        n = 0;
        while (val_cyc.size() < 2 && n < 50) begin @(posedge clk); #2; n++; end
        chk("full_reach_beat2", 128'(val_cyc.size() >= 2), 128'(1));
        full = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_ready_low", 128'(req_ready), 128'(0));
            pulses += int'(pkt_tx_val);
        end
        @(posedge clk);
        #1;
        full = 1'b0;
        chk("full_pulses_le1", 128'(pulses <= 1), 128'(1));
        drain("full");
        chk("full_beats", 128'(val_cyc.size()), 128'(6));

        // Back-to-back single-beat packets from source 1
        val_cyc.delete();
        for (int p = 0; p < 4; p++) push_pkt(1, 1, 8'(8'hA0 + p), 3'd0);
        drain("single_beat");
        exp_off = {0, 2, 4, 6};
        chk_spacing("single_beat");

        // Reset on beat 2 of a 5-beat packet
        val_cyc.delete();
        push_pkt(0, 5, 8'hC0, 3'd7);
        n = 0;
        while (val_cyc.size() < 2 && n < 50) begin @(negedge clk); #2; n++; end
        chk("mid_rst_reach_beat2", 128'(val_cyc.size()), 128'(2));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val",   128'(pkt_tx_val), 128'(0));
        chk("mid_rst_busy",  128'(busy),       128'(0));
        chk("mid_rst_grant", 128'(grant_id),   128'(0));
        srcq[0].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        val_cyc.delete();
        push_pkt(1, 3, 8'hD0, 3'd3);
        drain("post_rst");
        chk("post_rst_beats", 128'(val_cyc.size()), 128'(3));

`ifdef XGE_TX_ARB_STATS_EN
        // Per-source packet counters and wrap
        do_reset();
        for (int p = 0; p < 3; p++) push_pkt(0, 2, 8'(8'h10 + p), 3'd1);
        for (int p = 0; p < 2; p++) push_pkt(1, 2, 8'(8'h20 + p), 3'd2);
        drain("stats");
        chk("pkt_cnt", 128'(pkt_cnt), 128'({32'd2, 32'd3}));
        @(negedge clk);
        force dut.cnt_q = {32'd2, 32'hFFFF_FFFF};
        @(negedge clk);
        release dut.cnt_q;
        push_pkt(0, 1, 8'hEE, 3'd0);
        drain("stats_wrap");
        chk("pkt_cnt_wrap", 128'(pkt_cnt), 128'({32'd2, 32'd0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
